// File: rtl/pulse_period_meter_pkg.sv
// Shared types and defaults for the pulse period meter.
package pulse_period_meter_pkg;

  localparam int unsigned PPM_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } ppm_state_t;

endpackage

// File: rtl/pulse_period_meter_rise.sv
// Rising-edge detector: one-cycle strobe when d goes 0->1; no synchroniser.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise_c
);

  logic r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_d <= 1'b0;
    else     r_d <= i_d;
  end

  assign o_rise_c = i_d & ~r_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between successive rising edges of pulse_in and
// reports each interval with a one-cycle strobe; long intervals saturate.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH = PPM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             period_ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  ppm_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf_flag, w_ovf_nxt;
  logic             w_report;
  logic             w_rise;

  rise_detect u_rise (
    .clk      (clk),
    .rst      (rst),
    .i_d      (pulse_in),
    .o_rise_c (w_rise)
  );

  // Next-state and counter update; en dominates any coincident edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf_flag;
    w_report    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_ovf_nxt = 1'b0;
        if (en) w_state_nxt = ARM;
      end
      ARM: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (w_rise) begin
          w_state_nxt = MEAS;
          w_cnt_nxt   = WIDTH'(1);
          w_ovf_nxt   = 1'b0;
        end
      end
      MEAS: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (w_rise) begin
          w_report  = 1'b1;
          w_cnt_nxt = WIDTH'(1);
          w_ovf_nxt = 1'b0;
        end else if (r_cnt == CNT_MAX) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf_flag <= w_ovf_nxt;
    end
  end

  // Report registers hold between reports, including across en drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period       <= '0;
      period_ovf   <= 1'b0;
      period_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      period_valid <= w_report;
      busy         <= (w_state_nxt == MEAS);
      if (w_report) begin
        period     <= r_cnt;
        period_ovf <= r_ovf_flag;
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench: directed scenarios plus random pulse trains against a timestamp model.
module tb_pulse_period_meter;

  localparam int unsigned WIDTH = 8;
  localparam int          PMAX  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pulse_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             period_ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: timestamp of last measured edge, period = difference of timestamps.
  int cyc;
  int m_phase;      // 0 disabled, 1 waiting for first edge, 2 measuring
  int m_t_last;
  bit m_prev;
  int exp_period;
  bit exp_ovf, exp_valid, exp_busy;

  pulse_period_meter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pulse_in     (pulse_in),
    .period       (period),
    .period_valid (period_valid),
    .period_ovf   (period_ovf),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_prev     = 1'b0;
    m_t_last   = 0;
    exp_period = 0;
    exp_ovf    = 1'b0;
    exp_valid  = 1'b0;
    exp_busy   = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit p);
    bit rise;
    int d;
    rise = p && !m_prev;
    m_prev = p;
    exp_valid = 1'b0;
    if (m_phase == 0) begin
      if (e) m_phase = 1;
    end else if (!e) begin
      m_phase = 0;
    end else if (rise) begin
      if (m_phase == 2) begin
        d          = cyc - m_t_last;
        exp_valid  = 1'b1;
        exp_period = (d > PMAX) ? PMAX : d;
        exp_ovf    = (d > PMAX);
      end
      m_phase  = 2;
      m_t_last = cyc;
    end
    exp_busy = (m_phase == 2);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_valid"}, 32'(period_valid), 32'(exp_valid));
    check({tag, "_busy"},  32'(busy),         32'(exp_busy));
    check({tag, "_period"}, 32'(period),      exp_period);
    check({tag, "_ovf"},   32'(period_ovf),   32'(exp_ovf));
  endtask

  // One clock: drive on negedge, model at posedge, sample 1 ns later.
  task automatic step(input bit e, input bit p);
    @(negedge clk);
    en       = e;
    pulse_in = p;
    @(posedge clk);
    cyc++;
    model_step(e, p);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle_cycles(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, 1'b0);
  endtask

  // gap-1 low cycles, then a one-cycle high pulse.
  task automatic pulse_gap(input int gap);
    idle_cycles(gap - 1, 1'b1);
    step(1'b1, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_period", 32'(period), 0);
    check("rst_valid",  32'(period_valid), 0);
    check("rst_ovf",    32'(period_ovf), 0);
    check("rst_busy",   32'(busy), 0);
    rst = 1'b0;
  endtask

  initial begin
    int gap_left, high_left, en_low;
    bit e, p;
    cyc = 0;
    model_reset();
    rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Basic intervals
    idle_cycles(2, 1'b0);
    idle_cycles(3, 1'b1);
    step(1'b1, 1'b1);
    check("s1_no_report_on_arm", 32'(period_valid), 0);
    pulse_gap(5);
    check("s1_p5", 32'(period), 5);
    pulse_gap(10);
    check("s1_p10", 32'(period), 10);

    // Saturation boundary
    pulse_gap(255);
    check("s2_p255", 32'(period), 255);
    check("s2_p255_ovf", 32'(period_ovf), 0);
    pulse_gap(300);
    check("s2_sat", 32'(period), 255);
    check("s2_sat_ovf", 32'(period_ovf), 1);
    pulse_gap(256);
    check("s2_p256_ovf", 32'(period_ovf), 1);
    pulse_gap(5);
    check("s2_after_p5", 32'(period), 5);
    check("s2_after_ovf", 32'(period_ovf), 0);

    // Held-high input across enable; next real edges arm then measure
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("s3_no_valid", 32'(period_valid), 0);
    pulse_gap(4);
    pulse_gap(7);
    check("s3_p7", 32'(period), 7);

    // Enable drop discards interval, period held
    pulse_gap(3);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("s4_held", 32'(period), 3);
    step(1'b1, 1'b0);
    pulse_gap(4);
    check("s4_arm_only", 32'(period_valid), 0);
    pulse_gap(4);
    check("s4_p4", 32'(period), 4);

    // Async reset mid-interval
    pulse_gap(3);
    idle_cycles(2, 1'b1);
    async_reset();
    pulse_gap(2);
    check("s5_arm_only", 32'(period_valid), 0);
    pulse_gap(3);
    check("s5_p3", 32'(period), 3);

    // Toggling input
    for (int i = 0; i < 20; i++) step(1'b1, 1'(i % 2));
    check("s6_p2", 32'(period), 2);

    // Random pulse trains, enable drops and resets
    gap_left = 0; high_left = 0; en_low = 0;
    for (int i = 0; i < 4000; i++) begin
      if (gap_left == 0) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      gap_left = $urandom_range(2, 20);
        else if (r < 8) gap_left = $urandom_range(250, 262);
        else            gap_left = 2;
        high_left = $urandom_range(1, gap_left - 1);
      end
      p = (high_left > 0);
      if (high_left > 0) high_left--;
      gap_left--;
      if (en_low == 0 && $urandom_range(0, 199) == 0) en_low = $urandom_range(1, 3);
      e = (en_low == 0);
      if (en_low > 0) en_low--;
      if ($urandom_range(0, 999) == 0) async_reset();
      step(e, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
